pll_rst_sequencer: RTL

//  Parametrised PLL lock supervisor and multi-domain reset sequencer for N_CH PLL channels.

---
 rtl/fpga_rst_pkg.sv | 26 ++
 rtl/sync_bus.sv | 29 ++
 rtl/pll_rst_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fpga_rst_pkg.sv
// Shared types and helpers for the PLL lock supervisor / reset sequencer.
package fpga_rst_pkg;

  // Sequencer states; the encoding is exported on state_o for debug.
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } rstseq_state_t;

  // Bits needed to hold 0..max_val, never less than one bit so that
  // degenerate parameter choices (e.g. MAX_RETRY=0) still give a legal vector.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Larger of two integers, used to size counters shared between phases.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_bus.sv
// Multi-bit level synchroniser: every bit gets its own STAGES-deep flop chain.
// Bits are synchronised independently, so only use it for quasi-static levels
// such as PLL LOCKED flags, never for coherent multi-bit values.
module sync_bus #(
  parameter int WIDTH  = 2,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

    // Shift the asynchronous input bit through its chain; resets to "not locked"
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        chain <= '0;
      end else begin
        chain <= {chain[STAGES-2:0], d[gi]};
      end
    end

    assign q[gi] = chain[STAGES-1];
  end

endmodule

// File: rtl/pll_rst_sequencer.sv
// PLL lock supervisor and multi-domain reset sequencer.
// Holds the PLLs in reset, waits for a continuously stable combined lock,
// then releases the domain resets one by one in index order. Any loss of lock
// after release, or a software request, drops every domain back into reset
// together and restarts the sequence. Repeated lock timeouts end in FAULT.
module pll_rst_sequencer
  import fpga_rst_pkg::*;
#(
  parameter int N_CH             = 2,
  parameter int SYNC_STAGES      = 2,
  parameter int PLL_RST_CYC      = 64,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int REL_GAP_CYC      = 16,
  parameter int MAX_RETRY        = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_CH-1:0]                   pll_locked_i,
  input  logic                              sw_rst_req,
  output logic [N_CH-1:0]                   pll_rst,
  output logic [N_CH-1:0]                   dom_rst,
  output logic                              all_ready,
  output logic                              fault,
  output logic [cnt_width(MAX_RETRY)-1:0]   retry_cnt,
  output logic [2:0]                        state_o
);

  // Counter widths. The phase counter is shared by PLL_RST and RELEASE since
  // the two phases never overlap.
  localparam int RC_W = cnt_width(MAX_RETRY);
  localparam int PH_W = cnt_width(max_int(PLL_RST_CYC, REL_GAP_CYC));
  localparam int ST_W = cnt_width(LOCK_STABLE_CYC);
  localparam int TO_W = cnt_width(LOCK_TIMEOUT_CYC);
  localparam int IX_W = cnt_width(N_CH - 1);

  // Terminal counts: each phase ends on the cycle its counter shows LAST.
  localparam logic [PH_W-1:0] PLL_RST_LAST = PH_W'(PLL_RST_CYC - 1);
  localparam logic [PH_W-1:0] REL_GAP_LAST = PH_W'(REL_GAP_CYC - 1);
  localparam logic [ST_W-1:0] STABLE_LAST  = ST_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RC_W-1:0] RETRY_MAX    = RC_W'(MAX_RETRY);
  localparam logic [IX_W-1:0] LAST_CH      = IX_W'(N_CH - 1);
  localparam logic [IX_W-1:0] FIRST_GAP_CH = IX_W'(1);

  rstseq_state_t     state;
  logic [PH_W-1:0]   ph_cnt;      // PLL reset hold / release gap timer
  logic [ST_W-1:0]   stable_cnt;  // consecutive cycles with all locks high
  logic [TO_W-1:0]   to_cnt;      // cycles spent in the current WAIT_LOCK
  logic [IX_W-1:0]   rel_idx;     // next domain to release
  logic [N_CH-1:0]   lock_sync;
  logic              lk;
  logic              lock_lost;
  logic              restart;

  sync_bus #(
    .WIDTH  (N_CH),
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked_i),
    .q     (lock_sync)
  );

  // Combined lock: every PLL must report locked.
  assign lk = &lock_sync;

  // Lock only matters once domains have started leaving reset.
  assign lock_lost = !lk && ((state == RELEASE) || (state == RUN));

  // Software request and lock loss share one restart path; the request is
  // checked first in the FSM but both land in the same PLL_RST entry.
  assign restart = sw_rst_req || lock_lost;

  assign state_o = state;

  // Sequencer FSM: state, counters and every output live in this one register set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PLL_RST;
      pll_rst    <= '1;
      dom_rst    <= '1;
      all_ready  <= 1'b0;
      fault      <= 1'b0;
      retry_cnt  <= '0;
      ph_cnt     <= '0;
      stable_cnt <= '0;
      to_cnt     <= '0;
      rel_idx    <= '0;
    end else if (restart) begin
      // Full restart: all domains back into reset at once, fresh retry budget.
      state      <= PLL_RST;
      pll_rst    <= '1;
      dom_rst    <= '1;
      all_ready  <= 1'b0;
      fault      <= 1'b0;
      retry_cnt  <= '0;
      ph_cnt     <= '0;
      stable_cnt <= '0;
      to_cnt     <= '0;
      rel_idx    <= '0;
    end else begin
      case (state)
        PLL_RST: begin
          if (ph_cnt == PLL_RST_LAST) begin
            state      <= WAIT_LOCK;
            pll_rst    <= '0;
            ph_cnt     <= '0;
            stable_cnt <= '0;
            to_cnt     <= '0;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (lk && (stable_cnt == STABLE_LAST)) begin
            // Stable lock beats a timeout landing on the same cycle.
            dom_rst[0] <= 1'b0;
            ph_cnt     <= '0;
            stable_cnt <= '0;
            to_cnt     <= '0;
            rel_idx    <= FIRST_GAP_CH;
            if (N_CH == 1) begin
              state     <= RUN;
              all_ready <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else if (to_cnt == TIMEOUT_LAST) begin
            pll_rst    <= '1;
            ph_cnt     <= '0;
            stable_cnt <= '0;
            to_cnt     <= '0;
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= PLL_RST;
            end else begin
              fault <= 1'b1;
              state <= FAULT;
            end
          end else begin
            to_cnt     <= to_cnt + 1'b1;
            // Any unlocked cycle restarts the stability window from scratch.
            stable_cnt <= lk ? (stable_cnt + 1'b1) : '0;
          end
        end

        RELEASE: begin
          if (ph_cnt == REL_GAP_LAST) begin
            ph_cnt <= '0;
            for (int i = 0; i < N_CH; i++) begin
              if (rel_idx == IX_W'(i)) begin
                dom_rst[i] <= 1'b0;
              end
            end
            if (rel_idx == LAST_CH) begin
              state     <= RUN;
              all_ready <= 1'b1;
              rel_idx   <= '0;
            end else begin
              rel_idx <= rel_idx + 1'b1;
            end
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        RUN: begin
          // Nothing to do until a lock drops or software asks for a restart.
        end

        FAULT: begin
          // Parked with PLLs and domains in reset until software intervenes.
        end

        default: begin
          // Illegal encoding (e.g. upset): fall back to a clean restart.
          state      <= PLL_RST;
          pll_rst    <= '1;
          dom_rst    <= '1;
          all_ready  <= 1'b0;
          fault      <= 1'b0;
          retry_cnt  <= '0;
          ph_cnt     <= '0;
          stable_cnt <= '0;
          to_cnt     <= '0;
          rel_idx    <= '0;
        end
      endcase
    end
  end

endmodule
